// File: rtl/hart_bus_arb_pkg.sv
// Shared definitions for the hart bus arbiter: default line width, hart limit,
// FSM state encoding and a saturating counter helper.
package hart_bus_arb_pkg;

  localparam int HMEM_LINE      = 512;
  localparam int HART_ARB_N_MAX = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hart_bus_arb_rr_pick.sv
// Combinational round-robin picker: the first requester after index `last`,
// wrapping N-1 -> 0, returned both one-hot and as an index.
module hart_bus_arb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [IW-1:0] jw;
      jw = IW'((int'(last) + k) % N);
      if (!valid && req[jw]) begin
        valid     = 1'b1;
        grant[jw] = 1'b1;
        idx       = jw;
      end
    end
  end

endmodule

// File: rtl/hart_bus_arb.sv
// N-hart arbiter onto one line-wide memory port: round-robin grant, write
// invalidation broadcast, AMO bus lock. Optional counters: HART_ARB_PERF_EN.
module hart_bus_arb
  import hart_bus_arb_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int LINE_W  = HMEM_LINE,
  parameter int ADDR_W  = 64
) (
  input  logic                      h_clk,
  input  logic                      h_rst,
  input  logic [N_HARTS*ADDR_W-1:0] hx_addr,
  input  logic [N_HARTS-1:0]        hx_rd,
  input  logic [N_HARTS-1:0]        hx_wr,
  input  logic [N_HARTS*LINE_W-1:0] hx_data_out,
  output logic [LINE_W-1:0]         hx_data_in,
  output logic [N_HARTS-1:0]        hx_dv,
  output logic [N_HARTS-1:0]        hx_inv,
  output logic [ADDR_W-1:0]         hx_inv_addr,
  input  logic [N_HARTS-1:0]        hx_amo_req,
  output logic [N_HARTS-1:0]        hx_amo_ack,
  output logic [ADDR_W-1:0]         m_addr,
  output logic                      m_rd,
  output logic                      m_wr,
  output logic [LINE_W-1:0]         m_data_out,
  input  logic [LINE_W-1:0]         m_data_in,
  input  logic                      m_dv,
`ifdef HART_ARB_PERF_EN
  output logic [N_HARTS*32-1:0]     perf_grants,
  output logic [31:0]               perf_lock_wait,
`endif
  output arb_state_t                dbg_state
);

  localparam int IW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       gnt_q, rr_bus_q, rr_amo_q, holder_q, holder_d;
  logic [N_HARTS-1:0]  ack_q, ack_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   line_q;
  logic                wr_q;

  logic [N_HARTS-1:0]  bus_req, lock_mask, eligible, bus_oh, amo_oh, gnt_oh;
  logic [IW-1:0]       bus_idx, amo_idx;
  logic                bus_valid, amo_valid;
  logic                in_idle, busy, resp;

  assign in_idle   = (state_q == ARB_IDLE);
  assign busy      = (state_q == ARB_BUSY);
  assign resp      = (state_q == ARB_RESP);
  assign dbg_state = state_q;
  assign bus_req   = hx_rd | hx_wr;

  hart_bus_arb_rr_pick #(.N(N_HARTS), .IW(IW)) u_amo_pick (
    .req   (hx_amo_req),
    .last  (rr_amo_q),
    .grant (amo_oh),
    .idx   (amo_idx),
    .valid (amo_valid)
  );

  // Lock changes only in IDLE; the bus mask uses the lock state taking effect
  // this cycle so a fresh holder is not overtaken by a concurrent request.
  always_comb begin
    ack_d    = ack_q;
    holder_d = holder_q;
    if (in_idle) begin
      if (|ack_q) begin
        if (!hx_amo_req[holder_q]) ack_d = '0;
      end else if (amo_valid) begin
        ack_d    = amo_oh;
        holder_d = amo_idx;
      end
    end
  end

  assign lock_mask = (|ack_d) ? ack_d : '1;
  assign eligible  = bus_req & lock_mask;

  hart_bus_arb_rr_pick #(.N(N_HARTS), .IW(IW)) u_bus_pick (
    .req   (eligible),
    .last  (rr_bus_q),
    .grant (bus_oh),
    .idx   (bus_idx),
    .valid (bus_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (bus_valid) state_d = ARB_BUSY;
      ARB_BUSY: if (m_dv) state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_oh        = '0;
    gnt_oh[gnt_q] = 1'b1;
  end

  assign m_rd        = busy & ~wr_q;
  assign m_wr        = busy & wr_q;
  assign m_addr      = busy ? addr_q : '0;
  assign m_data_out  = (busy && wr_q) ? line_q : '0;
  assign hx_dv       = resp ? gnt_oh : '0;
  assign hx_data_in  = resp ? line_q : '0;
  assign hx_inv      = (resp && wr_q) ? ~gnt_oh : '0;
  assign hx_inv_addr = (resp && wr_q) ? addr_q : '0;
  assign hx_amo_ack  = ack_q;

  // line_q carries the write line on writes and the returned line on reads.
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      wr_q     <= 1'b0;
      rr_bus_q <= IW'(N_HARTS - 1);
      rr_amo_q <= IW'(N_HARTS - 1);
      ack_q    <= '0;
      holder_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      holder_q <= holder_d;
      if (in_idle && !(|ack_q) && amo_valid) rr_amo_q <= amo_idx;
      if (in_idle && bus_valid) begin
        gnt_q  <= bus_idx;
        addr_q <= hx_addr[bus_idx*ADDR_W +: ADDR_W];
        line_q <= hx_data_out[bus_idx*LINE_W +: LINE_W];
        wr_q   <= |(hx_wr & bus_oh);
      end
      if (busy && m_dv && !wr_q) line_q <= m_data_in;
      if (resp) rr_bus_q <= gnt_q;
    end
  end

`ifdef HART_ARB_PERF_EN
  logic [31:0] grants_q [N_HARTS];
  logic [31:0] lock_wait_q;

  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      for (int i = 0; i < N_HARTS; i++) grants_q[i] <= '0;
      lock_wait_q <= '0;
    end else begin
      if (resp) grants_q[gnt_q] <= sat_inc32(grants_q[gnt_q]);
      if (in_idle && |(bus_req & ~lock_mask)) lock_wait_q <= sat_inc32(lock_wait_q);
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < N_HARTS; i++) perf_grants[i*32 +: 32] = grants_q[i];
  end

  assign perf_lock_wait = lock_wait_q;
`endif

endmodule

// File: tb/tb_hart_bus_arb.sv
// Self-checking bench for hart_bus_arb (4 harts): directed scenarios plus random
// traffic against a queue-based round-robin reference and a 3-cycle memory model.
module tb_hart_bus_arb;
  import hart_bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int LW = 64;
  localparam int AW = 32;
  localparam int EW = 2 + 1 + AW + LW;

  // op: 0 read, 1 write, 2 read+write (served as write)
  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } txn_t;

  logic            h_clk = 1'b0;
  logic            h_rst;
  logic [N*AW-1:0] hx_addr;
  logic [N-1:0]    hx_rd, hx_wr, hx_dv, hx_inv, hx_amo_req, hx_amo_ack;
  logic [N*LW-1:0] hx_data_out;
  logic [LW-1:0]   hx_data_in, m_data_out, m_data_in;
  logic [AW-1:0]   hx_inv_addr, m_addr;
  logic            m_rd, m_wr, m_dv;
  arb_state_t      dbg_state;
`ifdef HART_ARB_PERF_EN
  logic [N*32-1:0] perf_grants;
  logic [31:0]     perf_lock_wait;
`endif

  int vectors = 0;
  int miscompares = 0;

  txn_t          hq [N][$];
  logic [EW-1:0] exp_q[$];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  logic [LW-1:0] mem [logic [AW-1:0]];
  int            rr_last;
  logic          scramble;

  hart_bus_arb #(.N_HARTS(N), .LINE_W(LW), .ADDR_W(AW)) dut (
    .h_clk       (h_clk),
    .h_rst       (h_rst),
    .hx_addr     (hx_addr),
    .hx_rd       (hx_rd),
    .hx_wr       (hx_wr),
    .hx_data_out (hx_data_out),
    .hx_data_in  (hx_data_in),
    .hx_dv       (hx_dv),
    .hx_inv      (hx_inv),
    .hx_inv_addr (hx_inv_addr),
    .hx_amo_req  (hx_amo_req),
    .hx_amo_ack  (hx_amo_ack),
    .m_addr      (m_addr),
    .m_rd        (m_rd),
    .m_wr        (m_wr),
    .m_data_out  (m_data_out),
    .m_data_in   (m_data_in),
    .m_dv        (m_dv),
`ifdef HART_ARB_PERF_EN
    .perf_grants    (perf_grants),
    .perf_lock_wait (perf_lock_wait),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 h_clk = ~h_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] dflt_line(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction

  // ---------------- memory model: m_dv three negedges after strobe seen ----------------
  int            mm_cnt = 0;
  logic          mm_pend = 1'b0;
  logic          mm_wr, log_wr;
  logic [AW-1:0] mm_addr, log_addr;
  logic [LW-1:0] mm_wdata, log_data;

  always @(negedge h_clk) begin
    logic fired;
    fired     = m_dv;
    m_dv      = 1'b0;
    m_data_in = {$urandom, $urandom};
    if (mm_pend) begin
      mm_cnt++;
      if (mm_cnt == 3) begin
        mm_pend = 1'b0;
        m_dv    = 1'b1;
        if (mm_wr) mem[mm_addr] = mm_wdata;
        else m_data_in = mem.exists(mm_addr) ? mem[mm_addr] : dflt_line(mm_addr);
        log_addr = mm_addr;
        log_wr   = mm_wr;
        log_data = mm_wr ? mm_wdata : m_data_in;
      end
    end else if (!fired && (m_rd || m_wr)) begin
      mm_pend  = 1'b1;
      mm_cnt   = 1;
      mm_addr  = m_addr;
      mm_wr    = m_wr;
      mm_wdata = m_data_out;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic txn_t mk_txn(input logic [1:0] op, input logic [AW-1:0] a, input logic [LW-1:0] d);
    txn_t t;
    t.op = op; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk_txn(2'($urandom_range(0, 2)), 32'h0001_0000 + 32'($urandom_range(0, 7)) * 32'h40,
                  {$urandom, $urandom});
  endfunction

  // Each hart presents its queue head; while scramble is set (bus busy) the
  // address/data lines carry junk, which the arbiter must not pick up.
  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (hq[i].size() > 0) begin
        hx_rd[i] = (hq[i][0].op != 2'd1);
        hx_wr[i] = (hq[i][0].op != 2'd0);
        hx_addr[i*AW +: AW]     = scramble ? $urandom : hq[i][0].addr;
        hx_data_out[i*LW +: LW] = scramble ? {$urandom, $urandom} : hq[i][0].data;
      end else begin
        hx_rd[i] = 1'b0;
        hx_wr[i] = 1'b0;
        hx_addr[i*AW +: AW]     = $urandom;
        hx_data_out[i*LW +: LW] = {$urandom, $urandom};
      end
    end
  endtask

  task automatic do_reset();
    h_rst      = 1'b1;
    hx_amo_req = '0;
    scramble   = 1'b0;
    for (int i = 0; i < N; i++) hq[i].delete();
    exp_q.delete();
    present();
    repeat (5) @(negedge h_clk);
    h_rst   = 1'b0;
    rr_last = N - 1;
  endtask

  // ---------------- reference model: round robin over pending hart queues ----------------
  task automatic build_expected(input logic [N-1:0] mask);
    int pos[N];
    int total = 0;
    int last  = rr_last;
    int g;
    logic wr;
    logic [LW-1:0] d;
    txn_t t;
    for (int i = 0; i < N; i++) begin
      pos[i] = 0;
      if (mask[i]) total += hq[i].size();
    end
    while (total > 0) begin
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && mask[(last + k) % N] && pos[(last + k) % N] < hq[(last + k) % N].size())
          g = (last + k) % N;
      t = hq[g][pos[g]];
      pos[g]++;
      total--;
      wr = (t.op != 2'd0);
      if (wr) begin
        ref_mem[t.addr] = t.data;
        d = t.data;
      end else begin
        d = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt_line(t.addr);
      end
      exp_q.push_back({2'(g), wr, t.addr, d});
      last = g;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic run_traffic(input int budget);
    int cyc = 0;
    logic [EW-1:0] e;
    logic [1:0] gb;
    logic wr;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic [N-1:0] oh;
    present();
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge h_clk);
      cyc++;
      if (hx_dv !== '0) begin
        e = exp_q.pop_front();
        {gb, wr, a, d} = e;
        oh = '0;
        oh[gb] = 1'b1;
        vectors++;
        if (hx_dv !== oh) begin
          miscompares++; $display("FAIL grant: hx_dv=%b expected %b", hx_dv, oh);
        end
        vectors++;
        if (log_addr !== a || log_wr !== wr) begin
          miscompares++; $display("FAIL mem_req: addr=%h wr=%b expected addr=%h wr=%b", log_addr, log_wr, a, wr);
        end
        if (wr) begin
          vectors++;
          if (log_data !== d) begin
            miscompares++; $display("FAIL wdata: m_data_out=%h expected %h", log_data, d);
          end
          vectors++;
          if (hx_inv !== ~oh || hx_inv_addr !== a) begin
            miscompares++; $display("FAIL inv: hx_inv=%b addr=%h expected %b addr=%h", hx_inv, hx_inv_addr, ~oh, a);
          end
        end else begin
          vectors++;
          if (hx_data_in !== d) begin
            miscompares++; $display("FAIL rdata: hx_data_in=%h expected %h", hx_data_in, d);
          end
          vectors++;
          if (hx_inv !== '0) begin
            miscompares++; $display("FAIL read_inv: hx_inv=%b expected 0", hx_inv);
          end
        end
        void'(hq[gb].pop_front());
        rr_last = int'(gb);
      end else begin
        vectors++;
        if (hx_inv !== '0) begin
          miscompares++; $display("FAIL stray_inv: hx_inv=%b expected 0", hx_inv);
        end
      end
      scramble = m_rd | m_wr;
      present();
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL timeout: %0d completions outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge h_clk);
    vectors++;
    if ({m_rd, m_wr, hx_dv, hx_inv, hx_amo_ack} !== '0) begin
      miscompares++; $display("FAIL reset_ctrl: rd=%b wr=%b dv=%b inv=%b ack=%b expected all 0", m_rd, m_wr, hx_dv, hx_inv, hx_amo_ack);
    end
    vectors++;
    if ({m_addr, m_data_out, hx_data_in, hx_inv_addr} !== '0) begin
      miscompares++; $display("FAIL reset_data: m_addr=%h m_data_out=%h hx_data_in=%h expected 0", m_addr, m_data_out, hx_data_in);
    end
    vectors++;
    if (dbg_state !== ARB_IDLE) begin
      miscompares++; $display("FAIL reset_state: %0d expected %0d", dbg_state, ARB_IDLE);
    end
  endtask

  task automatic test_single_read();
    int n = 1;
    logic [EW-1:0] e;
    do_reset();
    mem[32'h1000]     = 64'hC0DE_1000_BEEF_0001;
    ref_mem[32'h1000] = 64'hC0DE_1000_BEEF_0001;
    hq[0].push_back(mk_txn(2'd0, 32'h1000, 64'h0));
    build_expected(4'b0001);
    present();
    @(negedge h_clk);
    vectors++;
    if (m_rd !== 1'b1 || m_wr !== 1'b0 || m_addr !== 32'h1000) begin
      miscompares++; $display("FAIL first_strobe: m_rd=%b m_wr=%b m_addr=%h expected 1 0 00001000", m_rd, m_wr, m_addr);
    end
    while (hx_dv === '0 && n < 20) begin
      @(negedge h_clk);
      n++;
    end
    e = exp_q.pop_front();
    vectors++;
    if (n !== 4) begin
      miscompares++; $display("FAIL latency: %0d cycles expected 4", n);
    end
    vectors++;
    if (hx_dv !== 4'b0001 || hx_data_in !== e[LW-1:0]) begin
      miscompares++; $display("FAIL single_read: dv=%b data=%h expected 0001 %h", hx_dv, hx_data_in, e[LW-1:0]);
    end
    vectors++;
    if (m_rd !== 1'b0) begin
      miscompares++; $display("FAIL strobe_drop: m_rd=%b expected 0", m_rd);
    end
    void'(hq[0].pop_front());
    rr_last = 0;
    present();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++)
      repeat (2) hq[i].push_back(mk_txn(2'd0, 32'h0002_0000 + 32'($urandom_range(0, 15)) * 32'h40, 64'h0));
    build_expected(4'hF);
    run_traffic(200);
`ifdef HART_ARB_PERF_EN
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (perf_grants[i*32 +: 32] !== 32'd2) begin
        miscompares++; $display("FAIL perf_grants[%0d]: %0d expected 2", i, perf_grants[i*32 +: 32]);
      end
    end
`endif
  endtask

  task automatic test_write_inv();
    do_reset();
    hq[2].push_back(mk_txn(2'd1, 32'h2040, 64'hFEED_2040_0000_AAAA));
    build_expected(4'hF);
    run_traffic(50);
    hq[0].push_back(mk_txn(2'd0, 32'h2040, 64'h0));
    hq[1].push_back(mk_txn(2'd2, 32'h3000, 64'h1234_5678_9ABC_DEF0));
    hq[3].push_back(mk_txn(2'd0, 32'h3000, 64'h0));
    build_expected(4'hF);
    run_traffic(100);
  endtask

  task automatic test_amo_lock();
    do_reset();
    repeat (2) hq[1].push_back(mk_txn(2'd0, 32'h0003_0000 + 32'($urandom_range(0, 7)) * 32'h40, 64'h0));
    hq[0].push_back(mk_txn(2'd0, 32'h0003_1000, 64'h0));
    hq[3].push_back(mk_txn(2'd0, 32'h0003_3000, 64'h0));
    hx_amo_req = 4'b0010;
    build_expected(4'b0010);
    present();
    @(negedge h_clk);
    vectors++;
    if (hx_amo_ack !== 4'b0010) begin
      miscompares++; $display("FAIL amo_ack: %b expected 0010", hx_amo_ack);
    end
    run_traffic(60);
    repeat (8) begin
      @(negedge h_clk);
      vectors++;
      if (hx_dv !== '0 || hx_amo_ack !== 4'b0010) begin
        miscompares++; $display("FAIL lock_hold: dv=%b ack=%b expected 0000 0010", hx_dv, hx_amo_ack);
      end
    end
`ifdef HART_ARB_PERF_EN
    vectors++;
    if (perf_lock_wait == 32'd0) begin
      miscompares++; $display("FAIL perf_lock_wait: %0d expected nonzero", perf_lock_wait);
    end
`endif
    hx_amo_req = '0;
    @(negedge h_clk);
    vectors++;
    if (hx_amo_ack !== '0) begin
      miscompares++; $display("FAIL amo_release: %b expected 0000", hx_amo_ack);
    end
    build_expected(4'hF);
    run_traffic(60);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    hx_amo_req = 4'b0100;
    hq[2].push_back(mk_txn(2'd0, 32'h4000, 64'h0));
    present();
    while (m_rd !== 1'b1 && n < 10) begin
      @(negedge h_clk);
      n++;
    end
    vectors++;
    if (m_rd !== 1'b1 || hx_amo_ack !== 4'b0100) begin
      miscompares++; $display("FAIL mid_busy: m_rd=%b ack=%b expected 1 0100", m_rd, hx_amo_ack);
    end
    h_rst = 1'b1;
    @(negedge h_clk);
    vectors++;
    if (m_rd !== 1'b0 || hx_dv !== '0 || hx_amo_ack !== '0 || dbg_state !== ARB_IDLE) begin
      miscompares++; $display("FAIL mid_reset: m_rd=%b dv=%b ack=%b state=%0d expected 0 0 0 0", m_rd, hx_dv, hx_amo_ack, dbg_state);
    end
    h_rst = 1'b0;
    hx_amo_req = '0;
    hq[2].delete();
    present();
    repeat (6) begin
      @(negedge h_clk);
      vectors++;
      if (hx_dv !== '0 || m_rd !== 1'b0 || m_wr !== 1'b0) begin
        miscompares++; $display("FAIL late_m_dv: dv=%b rd=%b wr=%b expected all 0", hx_dv, m_rd, m_wr);
      end
    end
    rr_last = N - 1;
    for (int i = 0; i < N; i++) hq[i].push_back(mk_txn(2'd0, 32'h0004_0000 + 32'(i) * 32'h40, 64'h0));
    build_expected(4'hF);
    run_traffic(100);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        repeat ($urandom_range(0, 3)) hq[i].push_back(rand_txn());
      build_expected(4'hF);
      run_traffic(300);
      repeat ($urandom_range(0, 3)) @(negedge h_clk);
    end
  endtask

  initial begin
    h_rst       = 1'b1;
    hx_rd       = '0;
    hx_wr       = '0;
    hx_addr     = '0;
    hx_data_out = '0;
    hx_amo_req  = '0;
    m_dv        = 1'b0;
    m_data_in   = '0;
    scramble    = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_inv();
    test_amo_lock();
    test_reset_mid();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
